multdiv_ctrl: RTL

Sequencer for the shared multiply/divide resource behind the HI/LO registers. The main control unit enters its MULT or DIV state, pulses `start` with the operation and operands A and B, and waits for `done`. The block runs a 32-iteration signed Booth multiply or signed restoring divide, then produces a single HI/LO write strobe. For a zero divisor it raises a divide-by-zero flag instead of writing.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_step.sv | 56 +++++
 rtl/multdiv_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the main control unit.
// Holds the op encoding, the FSM state encoding and the default operand width.
package multdiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StWrite = 2'd2,
        StErr   = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration of either a radix-2 Booth multiply step or a
// restoring divide step on magnitudes, selected by op.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] ext_acc;
    logic [WIDTH:0] ext_m;
    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    // One guard bit keeps the Booth partial sum exact when m is the most negative value.
    assign ext_acc   = {acc[WIDTH-1], acc};
    assign ext_m     = {m[WIDTH-1], m};
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m};

    always_comb begin
        booth_sum = ext_acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = ext_acc + ext_m;
            2'b10:   booth_sum = ext_acc - ext_m;
            default: booth_sum = ext_acc;
        endcase
    end

    always_comb begin
        acc_next  = acc;
        q_next    = q;
        q_m1_next = 1'b0;
        if (op == OP_MULT) begin
            acc_next  = booth_sum[WIDTH:1];
            q_next    = {booth_sum[0], q[WIDTH-1:1]};
            q_m1_next = q[0];
        end else if (!div_diff[WIDTH]) begin
            acc_next = div_diff[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = div_shift[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: fixed 33-cycle latency, one
// HI/LO write strobe per result, or a divide-by-zero pulse instead of a write.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div0
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              op_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  q_q;
    logic              qm1_q;
    logic [WIDTH-1:0]  m_q;
    logic              qneg_q;
    logic              rneg_q;

    logic [WIDTH-1:0]  acc_nx;
    logic [WIDTH-1:0]  q_nx;
    logic              qm1_nx;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    multdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op        (op_q),
        .acc       (acc_q),
        .q         (q_q),
        .q_m1      (qm1_q),
        .m         (m_q),
        .acc_next  (acc_nx),
        .q_next    (q_nx),
        .q_m1_next (qm1_nx)
    );

    assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

    // Sign correction of the final divide iteration feeds the result registers directly.
    always_comb begin
        res_hi = acc_nx;
        res_lo = q_nx;
        if (op_q == OP_DIV) begin
            res_lo = qneg_q ? -q_nx : q_nx;
            res_hi = rneg_q ? -acc_nx : acc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            div0     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            div0     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q   <= op;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        qm1_q  <= 1'b0;
                        qneg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        rneg_q <= a_in[WIDTH-1];
                        busy   <= 1'b1;
                        if (op == OP_DIV) begin
                            q_q <= a_mag;
                            m_q <= b_mag;
                            if (b_in == '0) begin
                                state_q <= StErr;
                                div0    <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                state_q <= StRun;
                            end
                        end else begin
                            q_q     <= b_in;
                            m_q     <= a_in;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_nx;
                    q_q   <= q_nx;
                    qm1_q <= qm1_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q  <= StWrite;
                        hi_out   <= res_hi;
                        lo_out   <= res_lo;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                StWrite, StErr: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
